// File: rtl/alu_issue_sched_pkg.sv
// Shared widths, ALU micro-op codes and the scheduler entry layout for alu_issue_sched.
package alu_issue_sched_pkg;

  localparam int UOP_W  = 8;
  localparam int PREG_W = 7;
  localparam int ROB_W  = 6;

  localparam logic ABLE_VALUE   = 1'b1;
  localparam logic ENABLE_VALUE = 1'b1;

  typedef enum logic [UOP_W-1:0] {
    UOP_ADD  = 8'h00,
    UOP_SUB  = 8'h01,
    UOP_AND  = 8'h02,
    UOP_OR   = 8'h03,
    UOP_XOR  = 8'h04,
    UOP_SLL  = 8'h05,
    UOP_SRL  = 8'h06,
    UOP_SRA  = 8'h07,
    UOP_SLT  = 8'h08,
    UOP_SLTU = 8'h09,
    UOP_LUI  = 8'h0a,
    UOP_AUI  = 8'h0b
  } alu_uop_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [UOP_W-1:0]  uop;
    logic [19:0]       imm;
    logic              s1able;
    logic [PREG_W-1:0] s1addr;
    logic              s2able;
    logic [PREG_W-1:0] s2addr;
    logic              rdable;
    logic [PREG_W-1:0] rdaddr;
    logic [ROB_W-1:0]  robptr;
  } sched_pay_t;

  typedef struct packed {
    logic       valid;
    logic       s1rdy;
    logic       s2rdy;
    sched_pay_t pay;
  } sched_entry_t;

endpackage

// File: rtl/alu_issue_sched_age_matrix.sv
// Age matrix: older_r[i][j]=1 means entry i was allocated before entry j; grants the oldest requester.
module sched_age_matrix
  import alu_issue_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             Clk,
  input  logic             Rest,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] free_oh,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0] older_r [DEPTH];

  // A new entry is younger than everything present; a freed entry stops claiming seniority.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (Rest) begin
          older_r[i][j] <= 1'b0;
        end else if (alloc_oh[i]) begin
          older_r[i][j] <= 1'b0;
        end else if (alloc_oh[j] && (i != j)) begin
          older_r[i][j] <= 1'b1;
        end else if (free_oh[i]) begin
          older_r[i][j] <= 1'b0;
        end else begin
          older_r[i][j] <= older_r[i][j];
        end
      end
    end
  end

  // A requester wins unless some other requester is older than it.
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < DEPTH; j++) begin
        grant[i] = grant[i] & ~(req[j] & older_r[j][i]);
      end
    end
  end

endmodule

// File: rtl/alu_issue_sched.sv
// Integer issue scheduler in front of the single-cycle ALU: oldest-ready select with wakeup tracking.
// Optional performance counters are enabled by defining ALU_SCHED_PERF_EN.
module alu_issue_sched
  import alu_issue_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NWAKE = 5
) (
  input  logic                    Clk,
  input  logic                    Rest,
  input  logic                    Flash,
  input  logic                    DispAble,
  output logic                    DispReady,
  input  logic [31:0]             DispPc,
  input  logic [UOP_W-1:0]        DispUop,
  input  logic [19:0]             DispImm,
  input  logic                    DispS1Able,
  input  logic [PREG_W-1:0]       DispS1Addr,
  input  logic                    DispS1Rdy,
  input  logic                    DispS2Able,
  input  logic [PREG_W-1:0]       DispS2Addr,
  input  logic                    DispS2Rdy,
  input  logic                    DispRdAble,
  input  logic [PREG_W-1:0]       DispRdAddr,
  input  logic [ROB_W-1:0]        DispRobPtr,
  input  logic [NWAKE-1:0]        WakeAble,
  input  logic [NWAKE*PREG_W-1:0] WakeAddr,
  input  logic                    AluReq,
  output logic                    IssAble,
  output logic [31:0]             IssPc,
  output logic [UOP_W-1:0]        IssUop,
  output logic [19:0]             IssImm,
  output logic                    IssS1Able,
  output logic [PREG_W-1:0]       IssS1Addr,
  output logic                    IssS2Able,
  output logic [PREG_W-1:0]       IssS2Addr,
  output logic                    IssRdAble,
  output logic [PREG_W-1:0]       IssRdAddr,
  output logic [ROB_W-1:0]        IssRobPtr
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [31:0]             PerfIssCnt,
  output logic [31:0]             PerfFullCnt,
  output logic [31:0]             PerfStallCnt
`endif
);

  sched_entry_t     ent_r [DEPTH];
  sched_pay_t       iss_pay_r;
  logic             iss_able_r;
  logic [DEPTH-1:0] valid_s, cand_s, grant_s, free_slot_s, alloc_oh_s, free_oh_s;
  logic             found_s, alloc_s, issue_s;
  sched_pay_t       win_pay_s, disp_pay_s;

  function automatic logic wake_hit(input logic [NWAKE-1:0] able,
                                    input logic [NWAKE*PREG_W-1:0] addr,
                                    input logic [PREG_W-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NWAKE; i++) begin
      hit = hit | (able[i] & (addr[i*PREG_W +: PREG_W] == tag));
    end
    return hit;
  endfunction

  // Candidates use pre-wakeup state, giving one cycle from wakeup to issue.
  always_comb begin
    valid_s = '0;
    cand_s  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_s[i] = ent_r[i].valid;
      cand_s[i]  = ent_r[i].valid & ent_r[i].s1rdy & ent_r[i].s2rdy;
    end
  end

  // Lowest-index free slot receives the next dispatch.
  always_comb begin
    free_slot_s = '0;
    found_s     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_s[i] && !found_s) begin
        free_slot_s[i] = 1'b1;
        found_s        = 1'b1;
      end else begin
        free_slot_s[i] = 1'b0;
      end
    end
  end

  assign DispReady  = ~&valid_s;
  assign alloc_s    = DispAble & DispReady & ~Flash;
  assign issue_s    = AluReq & (|cand_s) & ~Flash;
  assign alloc_oh_s = free_slot_s & {DEPTH{alloc_s}};
  assign free_oh_s  = Flash ? {DEPTH{1'b1}} : (grant_s & {DEPTH{issue_s}});

  assign disp_pay_s = '{pc: DispPc, uop: DispUop, imm: DispImm,
                        s1able: DispS1Able, s1addr: DispS1Addr,
                        s2able: DispS2Able, s2addr: DispS2Addr,
                        rdable: DispRdAble, rdaddr: DispRdAddr, robptr: DispRobPtr};

  sched_age_matrix #(.DEPTH(DEPTH)) u_age (
    .Clk      (Clk),
    .Rest     (Rest),
    .alloc_oh (alloc_oh_s),
    .free_oh  (free_oh_s),
    .req      (cand_s),
    .grant    (grant_s)
  );

  // One-hot grant mux of the winning payload.
  always_comb begin
    win_pay_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      win_pay_s = sched_pay_t'(win_pay_s | (ent_r[i].pay & {$bits(sched_pay_t){grant_s[i]}}));
    end
  end

  // Entry state: allocation, wakeup and free; reset and flush discard everything.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (Rest || Flash) begin
        ent_r[i].valid <= 1'b0;
        ent_r[i].s1rdy <= 1'b0;
        ent_r[i].s2rdy <= 1'b0;
      end else if (alloc_oh_s[i]) begin
        ent_r[i].valid <= 1'b1;
        ent_r[i].s1rdy <= ~DispS1Able | DispS1Rdy | wake_hit(WakeAble, WakeAddr, DispS1Addr);
        ent_r[i].s2rdy <= ~DispS2Able | DispS2Rdy | wake_hit(WakeAble, WakeAddr, DispS2Addr);
        ent_r[i].pay   <= disp_pay_s;
      end else begin
        if (free_oh_s[i]) ent_r[i].valid <= 1'b0;
        if (wake_hit(WakeAble, WakeAddr, ent_r[i].pay.s1addr)) ent_r[i].s1rdy <= 1'b1;
        if (wake_hit(WakeAble, WakeAddr, ent_r[i].pay.s2addr)) ent_r[i].s2rdy <= 1'b1;
      end
    end
  end

  // Issue register: payload holds its last value whenever nothing issues.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      iss_able_r <= 1'b0;
      iss_pay_r  <= '0;
    end else if (Flash) begin
      iss_able_r <= 1'b0;
    end else if (issue_s) begin
      iss_able_r <= ABLE_VALUE;
      iss_pay_r  <= win_pay_s;
    end else begin
      iss_able_r <= 1'b0;
    end
  end

  assign IssAble   = iss_able_r;
  assign IssPc     = iss_pay_r.pc;
  assign IssUop    = iss_pay_r.uop;
  assign IssImm    = iss_pay_r.imm;
  assign IssS1Able = iss_pay_r.s1able;
  assign IssS1Addr = iss_pay_r.s1addr;
  assign IssS2Able = iss_pay_r.s2able;
  assign IssS2Addr = iss_pay_r.s2addr;
  assign IssRdAble = iss_pay_r.rdable;
  assign IssRdAddr = iss_pay_r.rdaddr;
  assign IssRobPtr = iss_pay_r.robptr;

`ifdef ALU_SCHED_PERF_EN
  // Counters survive flush and wrap naturally at 2^32.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      PerfIssCnt   <= 32'd0;
      PerfFullCnt  <= 32'd0;
      PerfStallCnt <= 32'd0;
    end else begin
      PerfIssCnt   <= PerfIssCnt + {31'd0, issue_s};
      PerfFullCnt  <= PerfFullCnt + {31'd0, &valid_s};
      PerfStallCnt <= PerfStallCnt + {31'd0, ~AluReq & (|cand_s)};
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched with an age-ordered queue model checked every cycle.
module tb_alu_issue_sched;

  logic        Clk, Rest, Flash, DispAble, DispReady;
  logic [31:0] DispPc;
  logic [7:0]  DispUop;
  logic [19:0] DispImm;
  logic        DispS1Able, DispS1Rdy, DispS2Able, DispS2Rdy, DispRdAble;
  logic [6:0]  DispS1Addr, DispS2Addr, DispRdAddr;
  logic [5:0]  DispRobPtr;
  logic [4:0]  WakeAble;
  logic [34:0] WakeAddr;
  logic        AluReq, IssAble;
  logic [31:0] IssPc;
  logic [7:0]  IssUop;
  logic [19:0] IssImm;
  logic        IssS1Able, IssS2Able, IssRdAble;
  logic [6:0]  IssS1Addr, IssS2Addr, IssRdAddr;
  logic [5:0]  IssRobPtr;

  alu_issue_sched dut (
    .Clk(Clk), .Rest(Rest), .Flash(Flash), .DispAble(DispAble), .DispReady(DispReady),
    .DispPc(DispPc), .DispUop(DispUop), .DispImm(DispImm),
    .DispS1Able(DispS1Able), .DispS1Addr(DispS1Addr), .DispS1Rdy(DispS1Rdy),
    .DispS2Able(DispS2Able), .DispS2Addr(DispS2Addr), .DispS2Rdy(DispS2Rdy),
    .DispRdAble(DispRdAble), .DispRdAddr(DispRdAddr), .DispRobPtr(DispRobPtr),
    .WakeAble(WakeAble), .WakeAddr(WakeAddr), .AluReq(AluReq), .IssAble(IssAble),
    .IssPc(IssPc), .IssUop(IssUop), .IssImm(IssImm),
    .IssS1Able(IssS1Able), .IssS1Addr(IssS1Addr), .IssS2Able(IssS2Able), .IssS2Addr(IssS2Addr),
    .IssRdAble(IssRdAble), .IssRdAddr(IssRdAddr), .IssRobPtr(IssRobPtr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks, errors;
  bit cmp_en;

  typedef struct {
    logic [89:0] pay;
    logic [6:0]  s1, s2;
    bit          s1rdy, s2rdy;
  } m_ent_t;

  m_ent_t      mq[$];
  logic        m_iss_able, m_disp_ready;
  logic [89:0] m_pay;

  wire [89:0] dut_pay  = {IssPc, IssUop, IssImm, IssS1Able, IssS1Addr, IssS2Able, IssS2Addr,
                          IssRdAble, IssRdAddr, IssRobPtr};
  wire [89:0] disp_pay = {DispPc, DispUop, DispImm, DispS1Able, DispS1Addr, DispS2Able, DispS2Addr,
                          DispRdAble, DispRdAddr, DispRobPtr};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit woke(input logic [6:0] t);
    for (int i = 0; i < 5; i++)
      if (WakeAble[i] && WakeAddr[i*7 +: 7] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Model: queue in allocation order; oldest ready entry issues; capacity 8.
  always @(posedge Clk) begin
    int win;
    bit do_alloc;
    m_ent_t e;
    if (Rest) begin
      mq.delete();
      m_iss_able = 1'b0;
      m_pay = '0;
    end else if (Flash) begin
      mq.delete();
      m_iss_able = 1'b0;
    end else begin
      win = -1;
      for (int k = 0; k < mq.size(); k++)
        if (win < 0 && mq[k].s1rdy && mq[k].s2rdy) win = k;
      do_alloc = DispAble && (mq.size() < 8);
      for (int k = 0; k < mq.size(); k++) begin
        if (woke(mq[k].s1)) mq[k].s1rdy = 1'b1;
        if (woke(mq[k].s2)) mq[k].s2rdy = 1'b1;
      end
      if (AluReq && win >= 0) begin
        m_iss_able = 1'b1;
        m_pay = mq[win].pay;
        mq.delete(win);
      end else begin
        m_iss_able = 1'b0;
      end
      if (do_alloc) begin
        e.pay   = disp_pay;
        e.s1    = DispS1Addr;
        e.s2    = DispS2Addr;
        e.s1rdy = !DispS1Able || DispS1Rdy || woke(DispS1Addr);
        e.s2rdy = !DispS2Able || DispS2Rdy || woke(DispS2Addr);
        mq.push_back(e);
      end
    end
    m_disp_ready = (mq.size() < 8);
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("model_iss_able", IssAble, m_iss_able);
      chk("model_iss_payload", dut_pay, m_pay);
      chk("model_disp_ready", DispReady, m_disp_ready);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic disp(input logic [5:0] ptr, input logic s1a, input logic [6:0] s1, input logic s1r,
                      input logic s2a, input logic [6:0] s2, input logic s2r);
    DispAble   = 1'b1;
    DispPc     = 32'h0000_1000 + {24'd0, ptr, 2'b00};
    DispUop    = {2'b00, ptr} ^ 8'hA5;
    DispImm    = {14'd0, ptr} + 20'h00100;
    DispS1Able = s1a; DispS1Addr = s1; DispS1Rdy = s1r;
    DispS2Able = s2a; DispS2Addr = s2; DispS2Rdy = s2r;
    DispRdAble = ptr[0];
    DispRdAddr = {1'b0, ptr};
    DispRobPtr = ptr;
  endtask

  task automatic set_wake(input int bus, input logic [6:0] tag);
    WakeAble[bus] = 1'b1;
    WakeAddr[bus*7 +: 7] = tag;
  endtask

  task automatic clr_wake();
    WakeAble = 5'd0;
    WakeAddr = 35'd0;
  endtask

  task automatic expect_iss(input string name, input logic [5:0] ptr);
    chk({name, "_able"}, IssAble, 1'b1);
    chk({name, "_rob"}, IssRobPtr, ptr);
  endtask

  initial begin
    checks = 0; errors = 0; cmp_en = 1'b0;
    Rest = 1'b1; Flash = 1'b0; AluReq = 1'b0;
    disp(6'd0, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0);
    DispAble = 1'b0;
    clr_wake();

    // Reset held two cycles
    step(); cmp_en = 1'b1; step(); Rest = 1'b0;
    chk("rst_iss_able", IssAble, 1'b0);
    chk("rst_disp_ready", DispReady, 1'b1);
    chk("rst_iss_pc", IssPc, 32'h0);
    chk("rst_iss_rob", IssRobPtr, 6'h0);

    // Ready at dispatch, then 8 back-to-back
    AluReq = 1'b1;
    disp(6'd1, 1'b1, 7'h01, 1'b1, 1'b0, 7'h00, 1'b0); step(); DispAble = 1'b0;
    chk("t2_not_yet", IssAble, 1'b0);
    step(); expect_iss("t2_first", 6'd1);
    chk("t2_first_pc", IssPc, 32'h0000_1004);
    for (int k = 0; k < 8; k++) begin
      disp(6'(8 + k), 1'b1, 7'h02, 1'b1, 1'b1, 7'h03, 1'b1); step();
      if (k > 0) expect_iss("t2_b2b", 6'(7 + k));
    end
    DispAble = 1'b0; step(); expect_iss("t2_last", 6'd15);
    step(); chk("t2_drained", IssAble, 1'b0);

    // Wakeup on bus 2, then same-cycle wakeup at dispatch on bus 4
    disp(6'd20, 1'b1, 7'h12, 1'b0, 1'b0, 7'h00, 1'b0); step(); DispAble = 1'b0;
    step(); chk("t3_waiting", IssAble, 1'b0);
    set_wake(2, 7'h12); step(); clr_wake();
    chk("t3_wake_edge", IssAble, 1'b0);
    step(); expect_iss("t3_woken", 6'd20);
    disp(6'd21, 1'b0, 7'h00, 1'b0, 1'b1, 7'h33, 1'b0); set_wake(4, 7'h33); step();
    DispAble = 1'b0; clr_wake();
    step(); expect_iss("t3_same_cycle", 6'd21);

    // Fill to 8 with nothing ready, 9th held off, wake one
    for (int k = 0; k < 8; k++) begin
      disp(6'(32 + k), 1'b1, 7'(8'h40 + k), 1'b0, 1'b0, 7'h00, 1'b0); step();
    end
    chk("t4_full", DispReady, 1'b0);
    disp(6'd40, 1'b1, 7'h7f, 1'b1, 1'b0, 7'h00, 1'b0); step();
    chk("t4_ignored_ready", DispReady, 1'b0);
    chk("t4_ignored_able", IssAble, 1'b0);
    set_wake(1, 7'h43); step(); clr_wake();
    chk("t4_wake_edge", IssAble, 1'b0);
    step(); expect_iss("t4_freed", 6'd35);
    chk("t4_ready_again", DispReady, 1'b1);
    step(); DispAble = 1'b0;
    step(); expect_iss("t4_held_dispatch", 6'd40);
    set_wake(0, 7'h40); set_wake(1, 7'h41); set_wake(2, 7'h42); set_wake(3, 7'h44); step();
    clr_wake(); set_wake(0, 7'h45); set_wake(1, 7'h46); set_wake(2, 7'h47); step(); clr_wake();
    expect_iss("t4_drain_first", 6'd32);
    repeat (8) step();

    // Age order independent of slot index: ptr 3 in slot 1, ptr 5 in slot 0
    disp(6'd2, 1'b1, 7'h01, 1'b1, 1'b0, 7'h00, 1'b0); step();
    disp(6'd3, 1'b1, 7'h50, 1'b0, 1'b0, 7'h00, 1'b0); step();
    expect_iss("t5_pre", 6'd2);
    disp(6'd5, 1'b1, 7'h51, 1'b0, 1'b0, 7'h00, 1'b0); step(); DispAble = 1'b0;
    set_wake(0, 7'h50); set_wake(3, 7'h51); step(); clr_wake();
    step(); expect_iss("t5_older", 6'd3);
    step(); expect_iss("t5_younger", 6'd5);
    AluReq = 1'b0;
    disp(6'd6, 1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b0); step(); chk("t5_stall1", IssAble, 1'b0);
    disp(6'd7, 1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b0); step(); chk("t5_stall2", IssAble, 1'b0);
    DispAble = 1'b0; step(); chk("t5_stall3", IssAble, 1'b0);
    AluReq = 1'b1;
    step(); expect_iss("t5_resume", 6'd6);
    step(); expect_iss("t5_resume2", 6'd7);

    // Flush with 5 waiting entries and a same-cycle dispatch
    for (int k = 0; k < 5; k++) begin
      disp(6'(50 + k), 1'b1, 7'(8'h60 + k), 1'b0, 1'b0, 7'h00, 1'b0); step();
    end
    disp(6'd55, 1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b0); Flash = 1'b1; step();
    Flash = 1'b0; DispAble = 1'b0;
    chk("t6_flush_able", IssAble, 1'b0);
    chk("t6_flush_ready", DispReady, 1'b1);
    for (int b = 0; b < 5; b++) set_wake(b, 7'(8'h60 + b));
    step(); clr_wake();
    repeat (3) begin
      step(); chk("t6_no_stale", IssAble, 1'b0);
    end
    disp(6'd56, 1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b0); step(); DispAble = 1'b0;
    step(); expect_iss("t6_post_flush", 6'd56);

    // Reset mid-operation discards a pending entry
    AluReq = 1'b0;
    disp(6'd60, 1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b0); step(); DispAble = 1'b0;
    Rest = 1'b1; step(); Rest = 1'b0; AluReq = 1'b1;
    chk("t7_rst_able", IssAble, 1'b0);
    chk("t7_rst_pc", IssPc, 32'h0);
    step(); step(); chk("t7_discarded", IssAble, 1'b0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
